// File: rtl/v2f_ram_lsu.sv
// Load/store unit in front of a v2f programmable RAM with a byte-select write port
// and a registered read port. It handles byte, halfword and word accesses and reports misaligned or illegal requests.
module v2f_ram_lsu #(
    parameter int ABITS = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [ABITS+1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             rd_en,
    output logic [ABITS-1:0] rd_addr,
    input  logic [31:0]      rd_data,
    output logic [31:0]      wr_en,
    output logic [ABITS-1:0] wr_addr,
    output logic [31:0]      wr_data,
    output logic [3:0]       byte_select
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t      state_reg;
    logic [1:0]  off_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic        req_err;
    logic        accept;
    logic        store_go;
    logic        load_go;
    logic [3:0]  lane_base;
    logic [31:0] shifted;
    logic [31:0] load_value;

    assign req_err  = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // Gating with arst_n keeps every RAM strobe quiet while reset is held.
    assign accept   = arst_n && req_valid && (state_reg == IDLE);
    assign store_go = accept && req_we && !req_err;
    assign load_go  = accept && !req_we && !req_err;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    assign rd_en   = load_go;
    assign rd_addr = req_addr[ABITS+1:2];
    assign wr_addr = req_addr[ABITS+1:2];
    assign wr_en   = {32{store_go}};

    assign lane_base   = (req_size == 2'b00) ? 4'b0001 :
                         (req_size == 2'b01) ? 4'b0011 : 4'b1111;
    assign byte_select = store_go ? (lane_base << req_addr[1:0]) : 4'b0000;

    // Replicate the right-aligned store data across every lane it may land in.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
        assign wr_data[8*gi +: 8] = (req_size == 2'b00) ? req_wdata[7:0] :
                                    (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                          req_wdata[8*gi +: 8];
    end

    assign shifted = rd_data >> {off_reg, 3'b000};

    always_comb begin
        load_value = shifted;
        case (size_reg)
            2'b00:   load_value = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   load_value = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg     <= IDLE;
            off_reg       <= 2'b00;
            size_reg      <= 2'b00;
            signed_reg    <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        off_reg       <= req_addr[1:0];
                        size_reg      <= req_size;
                        signed_reg    <= req_signed;
                        rsp_rdata_reg <= 32'h0;
                        rsp_err_reg   <= req_err;
                        state_reg     <= load_go ? RD_WAIT : RESP;
                    end
                end
                RD_WAIT: begin
                    rsp_rdata_reg <= load_value;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/v2f_ram_lsu.md
V2F_RAM_LSU -- requirements
Module: v2f_ram_lsu

Interface
REQ-001 Parameter ABITS, default 2: word-address width of the attached v2f programmable RAM (1 <= ABITS <= 30).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 ARST_N  input  1  asynchronous active-low reset.
REQ-004 REQ_VALID  input  1  initiator request valid.
REQ-005 REQ_READY  output  1  unit accepts a request this cycle.
REQ-006 REQ_WE  input  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 REQ_SIGNED  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 REQ_ADDR  input  ABITS+2  byte address; bits [1:0] select the byte lane.
REQ-010 REQ_WDATA  input  32  store data, right-aligned.
REQ-011 RSP_VALID / RSP_READY  output / input  1 / 1  response handshake.
REQ-012 RSP_RDATA  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-013 RSP_ERR  output  1  request was misaligned or illegal.
REQ-014 RD_EN  output  1; RD_ADDR  output  ABITS; RD_DATA  input  32  RAM read port; RAM registers its read data on the RD_EN edge.
REQ-015 WR_EN  output  32; WR_ADDR  output  ABITS; WR_DATA  output  32; BYTE_SELECT  output  4  RAM write port.

Function
REQ-016 The FSM SHALL have three states: IDLE, RD_WAIT, RESP.
REQ-017 REQ_READY SHALL be 1 only in IDLE; a request is accepted on the edge where REQ_VALID && REQ_READY.
REQ-018 A request is erroneous if REQ_SIZE=11, if REQ_SIZE=01 with REQ_ADDR[0]=1, or if REQ_SIZE=10 with REQ_ADDR[1:0]!=0.
REQ-019 Erroneous accept: no RAM strobe; next state RESP with RSP_ERR=1, RSP_RDATA=0.
REQ-020 Store accept (IDLE, combinational): WR_EN=all ones, WR_ADDR=REQ_ADDR[ABITS+1:2], BYTE_SELECT=0001/0011/1111 shifted left by REQ_ADDR[1:0], WR_DATA={4{byte}}, {2{half}} or the full word; the RAM writes on the accept edge; next state RESP with RSP_ERR=0, RSP_RDATA=0.
REQ-021 Load accept: RD_EN=1, RD_ADDR=REQ_ADDR[ABITS+1:2]; the unit registers the lane offset, size and signedness; next state RD_WAIT.
REQ-022 RD_WAIT: the unit samples RD_DATA, shifts it right by 8*offset, masks to size, sign- or zero-extends it into RSP_RDATA, and moves to RESP; this always takes exactly one cycle.
REQ-023 Outside an accepting IDLE cycle, RD_EN=0, WR_EN=0, BYTE_SELECT=0; WR_DATA and RD_ADDR are don't-care.
REQ-024 RESP: RSP_VALID=1, RSP_RDATA/RSP_ERR held stable until RSP_READY=1; on that edge go to IDLE; no request is accepted in the same cycle.
REQ-025 Latency from accept edge to RSP_VALID: store/error 1 cycle, load 2 cycles; peak throughput 1 request per 2 cycles (store) or 3 cycles (load).
REQ-026 Address wrap is impossible: REQ_ADDR width exactly covers the RAM; no bounds check.

Reset
REQ-027 While ARST_N=0: state IDLE, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RD_EN=0, WR_EN=0, BYTE_SELECT=0, independent of CLK.
REQ-028 Reset in RD_WAIT or RESP SHALL abort the transaction with no response; a store whose accept edge completed before reset remains written.
REQ-029 After ARST_N rises, REQ_READY=1 on the first cycle.

Verification
REQ-030 SW 0xDEADBEEF @0x4, then LW @0x4 -> store response 1 cycle after accept with RSP_ERR=0; load response 2 cycles after accept with RSP_RDATA=0xDEADBEEF.
REQ-031 SB 0x80 @0x5, then LB @0x5 gives 0xFFFFFF80, LBU @0x5 gives 0x00000080, LW @0x4 gives 0xDEAD80EF -> BYTE_SELECT=0010 during the SB accept.
REQ-032 SH 0x1234 @0x6, then LHU @0x6 gives 0x00001234 -> BYTE_SELECT=1100 and WR_DATA=0x12341234 during the accept.
REQ-033 LW @0x2, SH @0x1, REQ_SIZE=11 -> RSP_ERR=1, RSP_RDATA=0, RD_EN/WR_EN never asserted, memory unchanged.
REQ-034 RSP_READY held low 5 cycles after a load -> RSP_VALID and RSP_RDATA stable, REQ_READY=0 throughout; ARST_N pulsed low in RD_WAIT -> RSP_VALID never asserts and REQ_READY=1 after release.
